// File: rtl/ttech_mul_pkg.sv
// Shared helpers and FSM encoding for the three-way carry-less multiplier.
package ttech_mul_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int limb_w(input int n);
    return ceil_div(n, 3);
  endfunction

  function automatic int iter(input int w, input int d);
    return ceil_div(w, d);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, COMB, DRAIN} state_t;

endpackage

// File: rtl/gf2_digit_mac.sv
// Digit-serial GF(2) limb multiplier: each enabled cycle XORs in b_limb times
// one D-bit digit of a_limb, shifted into position.
module gf2_digit_mac
  import ttech_mul_pkg::*;
#(
  parameter int W     = 174,
  parameter int D     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [W-1:0]     a_limb,
  input  logic [W-1:0]     b_limb,
  output logic [2*W-2:0]   acc
);
  localparam int ITER  = iter(W, D);
  localparam int AW    = ITER * D;
  localparam int PW    = AW + W;
  localparam int ACC_W = 2 * W - 1;

  logic [AW-1:0] a_ext;
  logic [D-1:0]  digit;
  logic [PW-1:0] pp;

  // Zero padding makes the last digit read 0 past the limb's top bit.
  assign a_ext = AW'(a_limb);
  assign digit = D'(a_ext >> (int'(cnt) * D));

  always_comb begin
    pp = '0;
    for (int j = 0; j < D; j++)
      if (digit[j]) pp ^= PW'(b_limb) << j;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc ^ ACC_W'(pp << (int'(cnt) * D));
  end

endmodule

// File: rtl/three_way_toom_cook_seq.sv
// Handshaked N-bit carry-less multiplier: three-limb split, nine digit-serial
// limb products, XOR recombination and an optional output delay line.
module three_way_toom_cook_seq
  import ttech_mul_pkg::*;
#(
  parameter int N    = 521,
  parameter int D    = 1,
  parameter int PIPE = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);
  localparam int W     = limb_w(N);
  localparam int ITER  = iter(W, D);
  localparam int CNT_W = (ITER > 1) ? clog2(ITER) : 1;
  localparam int PD    = (PIPE > 0) ? PIPE : 1;
  localparam int DCW   = (PD > 1) ? clog2(PD) : 1;
  localparam int CW    = 6 * W;
  localparam int CN    = 2 * N;

  state_t                  state;
  logic [N-1:0]            a_q, b_q;
  logic [CNT_W-1:0]        cnt;
  logic [DCW-1:0]          dcnt;
  logic [PD-1:0][CN-1:0]   pipe_q;
  logic [2:0][W-1:0]       al, bl;
  logic [2:0][2:0][2*W-2:0] prod;
  logic [CN-1:0]           c_int;
  logic                    clr, en;

  assign al[0] = a_q[W-1:0];
  assign al[1] = a_q[2*W-1:W];
  assign al[2] = W'(a_q[N-1:2*W]);
  assign bl[0] = b_q[W-1:0];
  assign bl[1] = b_q[2*W-1:W];
  assign bl[2] = W'(b_q[N-1:2*W]);

  assign clr = (state == IDLE) && start;
  assign en  = (state == RUN);

  for (genvar i = 0; i < 3; i++) begin : g_a
    for (genvar j = 0; j < 3; j++) begin : g_b
      gf2_digit_mac #(.W(W), .D(D), .CNT_W(CNT_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .cnt    (cnt),
        .a_limb (al[i]),
        .b_limb (bl[j]),
        .acc    (prod[i][j])
      );
    end
  end

  // Product a_i*b_j lands at limb offset (i+j)*W; bits above 2N are zero.
  always_comb begin
    c_int = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        c_int ^= CN'(CW'(prod[i][j]) << ((i + j) * W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      c      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      dcnt   <= '0;
      pipe_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) state <= COMB;
        end
        COMB: begin
          pipe_q[0] <= c_int;
          dcnt      <= '0;
          if (PIPE == 0) begin
            c     <= c_int;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          for (int s = 1; s < PD; s++) pipe_q[s] <= pipe_q[s-1];
          dcnt <= dcnt + 1'b1;
          if (dcnt == DCW'(PD - 1)) begin
            c     <= pipe_q[PD-1];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_three_way_toom_cook_seq.sv
// Randomized and directed bench for three multiplier configurations running in
// parallel, checked against a bit-by-bit carry-less multiply model.
module tb_three_way_toom_cook_seq;
  localparam int NA = 521;
  localparam int NB = 64;
  localparam int NC = 7;

  typedef logic [2*NA-1:0] wide_t;
  typedef logic [NA-1:0]   opa_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, start_a, busy_a, done_a;
  logic [NA-1:0]   a_a, b_a;
  logic [2*NA-1:0] c_a;
  logic            rst_b, start_b, busy_b, done_b;
  logic [NB-1:0]   a_b, b_b;
  logic [2*NB-1:0] c_b;
  logic            rst_c, start_c, busy_c, done_c;
  logic [NC-1:0]   a_c, b_c;
  logic [2*NC-1:0] c_c;

  three_way_toom_cook_seq #(.N(NA), .D(1), .PIPE(3)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .a(a_a), .b(b_a),
    .busy(busy_a), .done(done_a), .c(c_a));
  three_way_toom_cook_seq #(.N(NB), .D(8), .PIPE(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .a(a_b), .b(b_b),
    .busy(busy_b), .done(done_b), .c(c_b));
  three_way_toom_cook_seq #(.N(NC), .D(3), .PIPE(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .a(a_c), .b(b_c),
    .busy(busy_c), .done(done_c), .c(c_c));

  int n_chk  = 0;
  int n_fail = 0;

  function automatic wide_t clmul(input opa_t x, input opa_t y);
    wide_t r;
    r = '0;
    for (int i = 0; i < NA; i++)
      if (x[i]) r ^= wide_t'(y) << i;
    return r;
  endfunction

  function automatic opa_t rnd();
    opa_t r;
    r = '0;
    for (int i = 0; i < 17; i++) r = {r[NA-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic chk(input string tag, input wide_t got, input wide_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  task automatic op_a(input opa_t x, input opa_t y, output int lat);
    a_a = x; b_a = y; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done_a && lat < 400);
  endtask

  task automatic op_b(input logic [NB-1:0] x, input logic [NB-1:0] y, output int lat);
    a_b = x; b_b = y; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done_b && lat < 20);
  endtask

  task automatic op_c(input logic [NC-1:0] x, input logic [NC-1:0] y, output int lat);
    a_c = x; b_c = y; start_c = 1'b1;
    @(posedge clk); #1; start_c = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done_c && lat < 20);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; start_a = 1'b0; a_a = '0; b_a = '0;
    rst_b = 1'b1; start_b = 1'b0; a_b = '0; b_b = '0;
    rst_c = 1'b1; start_c = 1'b0; a_c = '0; b_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_busy", wide_t'(busy_a), '0);
    chk("rst_a_done", wide_t'(done_a), '0);
    chk("rst_a_c", c_a, '0);
    chk("rst_b_c", wide_t'(c_b), '0);
    chk("rst_c_c", wide_t'(c_c), '0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    fork
      begin : p_a
        int lat, nd, first;
        opa_t x, y, x2, y2;
        wide_t e;
        // basic products and latency
        op_a(opa_t'(1), opa_t'(1), lat);
        chk("a_1x1_lat", wide_t'(lat), wide_t'(178));
        chk("a_1x1_c", c_a, wide_t'(1));
        op_a(opa_t'(3), opa_t'(3), lat);
        chk("a_3x3_lat", wide_t'(lat), wide_t'(178));
        chk("a_3x3_c", c_a, wide_t'(5));
        // top limb and truncation
        x = '0; x[NA-1] = 1'b1;
        e = '0; e[2*NA-2] = 1'b1;
        op_a(x, x, lat);
        chk("a_top_c", c_a, e);
        x = '1;
        e = '0;
        for (int i = 0; i < 2*NA; i += 2) e[i] = 1'b1;
        op_a(x, x, lat);
        chk("a_ones_c", c_a, e);
        for (int r = 0; r < 4; r++) begin
          x = rnd(); y = rnd();
          op_a(x, y, lat);
          chk("a_rnd_lat", wide_t'(lat), wide_t'(178));
          chk("a_rnd_c", c_a, clmul(x, y));
        end
        // start pulses while busy are ignored
        x = rnd(); y = rnd();
        a_a = x; b_a = y; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        chk("a_busy_hi", wide_t'(busy_a), wide_t'(1));
        nd = 0; first = 0;
        for (int k = 1; k <= 178; k++) begin
          if (k == 10 || k == 100) begin a_a = rnd(); b_a = rnd(); start_a = 1'b1; end
          @(posedge clk); #1; start_a = 1'b0;
          if (done_a) begin nd++; if (first == 0) first = k; end
        end
        chk("a_ign_ndone", wide_t'(nd), wide_t'(1));
        chk("a_ign_lat", wide_t'(first), wide_t'(178));
        chk("a_ign_c", c_a, clmul(x, y));
        chk("a_done_busy", wide_t'(busy_a), '0);
        // start in the done cycle
        x2 = rnd(); y2 = rnd();
        op_a(x2, y2, lat);
        chk("a_b2b_lat", wide_t'(lat), wide_t'(178));
        chk("a_b2b_c", c_a, clmul(x2, y2));
        nd = 0;
        repeat (200) begin @(posedge clk); #1; if (done_a) nd++; end
        chk("a_no_extra_done", wide_t'(nd), '0);
        // reset mid-operation
        e = c_a;
        a_a = rnd(); b_a = rnd(); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("a_c_hold", c_a, e);
        rst_a = 1'b1;
        @(posedge clk); #1; rst_a = 1'b0;
        chk("a_mid_rst_busy", wide_t'(busy_a), '0);
        chk("a_mid_rst_c", c_a, '0);
        nd = 0;
        repeat (250) begin @(posedge clk); #1; if (done_a) nd++; end
        chk("a_abort_ndone", wide_t'(nd), '0);
        // reset beats start
        a_a = rnd(); start_a = 1'b1; rst_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; rst_a = 1'b0;
        chk("a_rst_start_busy", wide_t'(busy_a), '0);
        x = rnd(); y = rnd();
        op_a(x, y, lat);
        chk("a_post_rst_lat", wide_t'(lat), wide_t'(178));
        chk("a_post_rst_c", c_a, clmul(x, y));
      end
      begin : p_b
        int lat;
        logic [NB-1:0] x, y;
        for (int r = 0; r < 1000; r++) begin
          x = {32'($urandom), 32'($urandom)};
          y = {32'($urandom), 32'($urandom)};
          op_b(x, y, lat);
          chk("b_lat", wide_t'(lat), wide_t'(4));
          chk("b_c", wide_t'(c_b), clmul(opa_t'(x), opa_t'(y)));
        end
      end
      begin : p_c
        int lat;
        for (int x = 0; x < 128; x++)
          for (int y = 0; y < 128; y++) begin
            op_c(7'(x), 7'(y), lat);
            chk("c_lat", wide_t'(lat), wide_t'(3));
            chk("c_c", wide_t'(c_c), clmul(opa_t'(x), opa_t'(y)));
          end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
